// File: rtl/bit_counter_seq.sv
// Sequential population counter: counts CHUNK bits per clock over a BITSIZE-wide word,
// with valid/ready on both sides and a saturating running total of delivered counts.
module bit_counter_seq #(
  parameter int BITSIZE     = 10,
  parameter int CHUNK       = 4,
  parameter int COUNTERSIZE = $clog2(BITSIZE + 1),
  parameter int ACCSIZE     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITSIZE-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNTERSIZE-1:0] out_count,
  input  logic                   clear_acc,
  output logic [ACCSIZE-1:0]     acc_total,
  output logic                   acc_sat
);

  localparam int NCHUNK = (BITSIZE + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int IDXW   = $clog2(NCHUNK + 1);
  localparam int ACCW1  = ACCSIZE + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [PADW-1:0]        r_word;
  logic [IDXW-1:0]        r_idx;
  logic [COUNTERSIZE-1:0] r_partial;
  logic [COUNTERSIZE-1:0] r_out_count;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [ACCSIZE-1:0]     r_acc;
  logic                   r_acc_sat;

  logic [CHUNK-1:0]       w_chunk;
  logic [COUNTERSIZE-1:0] w_chunk_pop;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_deliver;
  logic [ACCSIZE:0]       w_acc_base;
  logic [ACCSIZE:0]       w_acc_sum;
  logic                   w_acc_clamp;
  logic                   w_sat_base;

  function automatic logic [COUNTERSIZE-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [COUNTERSIZE-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s = s + COUNTERSIZE'(v[i]);
    end
    return s;
  endfunction

  // Chunk selection, handshake decode and accumulator arithmetic
  always_comb begin
    // r_word is zero-padded above BITSIZE, so the last partial chunk is already masked
    w_chunk     = CHUNK'(r_word >> (32'(r_idx) * CHUNK));
    w_chunk_pop = popcount(w_chunk);
    w_last      = (r_idx == IDXW'(NCHUNK));
    w_accept    = in_valid & r_in_ready;
    w_deliver   = r_out_valid & out_ready;
    w_acc_base  = clear_acc ? '0 : {1'b0, r_acc};
    w_sat_base  = clear_acc ? 1'b0 : r_acc_sat;
    w_acc_sum   = w_acc_base + ACCW1'(r_out_count);
    w_acc_clamp = w_acc_sum[ACCSIZE] | (&w_acc_sum[ACCSIZE-1:0]);
  end

  // Control FSM and per-word counting datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_partial   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_word     <= PADW'(in_data);
            r_partial  <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_out_count <= r_partial;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_partial <= r_partial + w_chunk_pop;
            r_idx     <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (w_deliver) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_idx       <= '0;
          r_partial   <= '0;
        end
      endcase
    end
  end

  // Saturating running total; a same-cycle clear restarts the sum from this word's count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
    end else if (w_deliver) begin
      r_acc     <= w_acc_clamp ? '1 : w_acc_sum[ACCSIZE-1:0];
      r_acc_sat <= w_sat_base | w_acc_clamp;
    end else if (clear_acc) begin
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
    end else begin
      r_acc     <= r_acc;
      r_acc_sat <= r_acc_sat;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign acc_total = r_acc;
  assign acc_sat   = r_acc_sat;

endmodule
